// File: rtl/agp32_mem_responder.sv
// rtl/agp32_mem_responder.sv - command/ready memory responder for the agp32 core, word RAM with programmable latency
// Optional preload port enabled by AGP32_MEM_LOAD_PORT_EN.
module agp32_mem_responder #(
   parameter int DEPTH       = 1024,
   parameter int LATENCY     = 2,
   parameter int INIT_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  command,
   input  logic [31:0] PC,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   input  logic [3:0]  data_wstrb,
`ifdef AGP32_MEM_LOAD_PORT_EN
   input  logic        load_en,
   input  logic [31:0] load_addr,
   input  logic [31:0] load_data,
`endif
   output logic        ready,
   output logic [31:0] inst_rdata,
   output logic [31:0] data_rdata,
   output logic        mem_start_ready,
   output logic [1:0]  error
);

   localparam int          IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [31:0] ADDR_LIM = 32'(4 * DEPTH);
   localparam logic [31:0] NOP_WORD = 32'd63;

   typedef enum logic [1:0] {
      S_INIT,
      S_IDLE,
      S_BUSY,
      S_ERR
   } state_t;

   state_t             r_state;
   state_t             w_state_nx;

   logic [31:0]        r_mem [DEPTH];

   logic               r_ready;
   logic               r_msr;
   logic [31:0]        r_inst;
   logic [31:0]        r_data;
   logic [1:0]         r_err;
   logic [7:0]         r_cnt;

   logic [2:0]         r_cmd;
   logic [IDX_W-1:0]   r_pidx;
   logic [IDX_W-1:0]   r_didx;
   logic [31:0]        r_wdata;
   logic [3:0]         r_wstrb;

   logic               w_capture;
   logic               w_complete;
   logic               w_init_done;
   logic               w_err_set;
   logic [1:0]         w_err_code;
   logic               w_uses_data;
   logic               w_range_err;
   logic               w_align_err;
   logic               w_load_hold;
   logic               w_wr_en;
   logic [31:0]        w_dword;
   logic [31:0]        w_pword;
   logic [31:0]        w_merged;
   logic [31:0]        w_inst_next;

`ifdef AGP32_MEM_LOAD_PORT_EN
   logic               w_load_we;
   assign w_load_hold = load_en;
   assign w_load_we   = load_en && ((r_state == S_INIT) || (r_state == S_IDLE))
                        && (load_addr < 32'(DEPTH));
`else
   assign w_load_hold = 1'b0;
`endif

   assign w_uses_data = (command == 3'd2) || (command == 3'd3);
   assign w_range_err = (PC >= ADDR_LIM) || (w_uses_data && (data_addr >= ADDR_LIM));
   assign w_align_err = (PC[1:0] != 2'b00) ||
                        ((command == 3'd3) && (data_wstrb == 4'hF) && (data_addr[1:0] != 2'b00));

   // Captured indices are only dereferenced after the range check has passed.
   assign w_dword = r_mem[r_didx];
   assign w_pword = r_mem[r_pidx];

   always_comb begin
      w_merged = w_dword;
      for (int b = 0; b < 4; b++) begin
         if (r_wstrb[b]) begin
            w_merged[8*b +: 8] = r_wdata[8*b +: 8];
         end
      end
   end

   // Fetch observes the write issued in the same completion cycle.
   assign w_inst_next = ((r_cmd == 3'd3) && (r_pidx == r_didx)) ? w_merged : w_pword;

   // Pending write is dropped if reset lands on the completion edge.
   assign w_wr_en = w_complete && (r_cmd == 3'd3) && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_INIT;
      end else begin
         r_state <= w_state_nx;
      end
   end

   always_comb begin
      w_state_nx  = r_state;
      w_capture   = 1'b0;
      w_complete  = 1'b0;
      w_init_done = 1'b0;
      w_err_set   = 1'b0;
      w_err_code  = 2'd0;
      case (r_state)
         S_INIT: begin
            if (!w_load_hold && (r_cnt <= 8'd1)) begin
               w_init_done = 1'b1;
               w_state_nx  = S_IDLE;
            end
         end
         S_IDLE: begin
            if (r_ready) begin
               if ((command >= 3'd1) && (command <= 3'd4)) begin
                  if (w_range_err) begin
                     w_err_set  = 1'b1;
                     w_err_code = 2'd1;
                     w_state_nx = S_ERR;
                  end else if (w_align_err) begin
                     w_err_set  = 1'b1;
                     w_err_code = 2'd2;
                     w_state_nx = S_ERR;
                  end else begin
                     w_capture  = 1'b1;
                     w_state_nx = S_BUSY;
                  end
               end else if (command >= 3'd5) begin
                  w_err_set  = 1'b1;
                  w_err_code = 2'd3;
                  w_state_nx = S_ERR;
               end
            end
         end
         S_BUSY: begin
            if (r_cnt <= 8'd1) begin
               w_complete = 1'b1;
               w_state_nx = S_IDLE;
            end
         end
         S_ERR: begin
            w_state_nx = S_ERR;
         end
         default: begin
            w_state_nx = S_INIT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ready <= 1'b0;
         r_msr   <= 1'b0;
         r_inst  <= NOP_WORD;
         r_data  <= 32'd0;
         r_err   <= 2'd0;
         r_cnt   <= 8'(INIT_CYCLES);
      end else begin
         case (r_state)
            S_INIT: begin
               if (w_init_done) begin
                  r_ready <= 1'b1;
                  r_msr   <= 1'b1;
               end else if (!w_load_hold) begin
                  r_cnt <= r_cnt - 8'd1;
               end
            end
            S_IDLE: begin
               if (w_capture) begin
                  r_ready <= 1'b0;
                  r_cnt   <= 8'(LATENCY);
                  r_cmd   <= command;
                  r_pidx  <= PC[IDX_W+1:2];
                  r_didx  <= data_addr[IDX_W+1:2];
                  r_wdata <= data_wdata;
                  r_wstrb <= data_wstrb;
               end else if (w_err_set) begin
                  r_err <= w_err_code;
               end
            end
            S_BUSY: begin
               if (w_complete) begin
                  r_ready <= 1'b1;
                  r_inst  <= w_inst_next;
                  if (r_cmd == 3'd2) begin
                     r_data <= w_dword;
                  end
               end else begin
                  r_cnt <= r_cnt - 8'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[r_didx] <= w_merged;
      end
`ifdef AGP32_MEM_LOAD_PORT_EN
      if (w_load_we) begin
         r_mem[load_addr[IDX_W-1:0]] <= load_data;
      end
`endif
   end

   assign ready           = r_ready;
   assign inst_rdata      = r_inst;
   assign data_rdata      = r_data;
   assign mem_start_ready = r_msr;
   assign error           = r_err;

endmodule

// File: tb/tb_agp32_mem_responder.sv
// tb/tb_agp32_mem_responder.sv - directed table-driven bench for agp32_mem_responder
module tb_agp32_mem_responder;

   logic        clk;
   logic        rst;
   logic [2:0]  command;
   logic [31:0] PC;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic [3:0]  data_wstrb;
   logic        ready;
   logic [31:0] inst_rdata;
   logic [31:0] data_rdata;
   logic        mem_start_ready;
   logic [1:0]  error;
`ifdef AGP32_MEM_LOAD_PORT_EN
   logic        load_en;
   logic [31:0] load_addr;
   logic [31:0] load_data;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   agp32_mem_responder dut (
      .clk             (clk),
      .rst             (rst),
      .command         (command),
      .PC              (PC),
      .data_addr       (data_addr),
      .data_wdata      (data_wdata),
      .data_wstrb      (data_wstrb),
`ifdef AGP32_MEM_LOAD_PORT_EN
      .load_en         (load_en),
      .load_addr       (load_addr),
      .load_data       (load_data),
`endif
      .ready           (ready),
      .inst_rdata      (inst_rdata),
      .data_rdata      (data_rdata),
      .mem_start_ready (mem_start_ready),
      .error           (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  cmd;
      logic [31:0] pc;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] exp_inst;
      logic [31:0] exp_data;
      logic [1:0]  exp_err;
      int          exp_lat;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst     = 1'b1;
      command = 3'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_start(output int n);
      n = 0;
      while (!mem_start_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
   endtask

   // Junk write is driven while busy; it must never be captured.
   task automatic issue(input logic [2:0] c, input logic [31:0] pc, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] ws, output int lat);
      int guard;
      guard = 0;
      while (!ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (!ready) begin
         n_tests++;
         n_fail++;
         $display("FAIL issue_wait: ready stayed 0 for %0d cycles, expected 1", guard);
      end
      command    = c;
      PC         = pc;
      data_addr  = a;
      data_wdata = wd;
      data_wstrb = ws;
      @(negedge clk);
      lat = 0;
      while (!ready && lat < 50) begin
         lat++;
         command    = 3'd3;
         PC         = 32'h100;
         data_addr  = 32'h100;
         data_wdata = 32'h0;
         data_wstrb = 4'hF;
         @(negedge clk);
      end
      command = 3'd0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      int lat;

      rst        = 1'b1;
      command    = 3'd0;
      PC         = 32'h0;
      data_addr  = 32'h0;
      data_wdata = 32'h0;
      data_wstrb = 4'h0;
`ifdef AGP32_MEM_LOAD_PORT_EN
      load_en    = 1'b0;
      load_addr  = 32'h0;
      load_data  = 32'h0;
`endif

      vecs[0]  = '{3'd3, 32'h4,   32'h4,        32'h12345678, 4'hF, 32'h12345678, 32'h0,        2'd0, 2};
      vecs[1]  = '{3'd1, 32'h4,   32'h0,        32'h0,        4'h0, 32'h12345678, 32'h0,        2'd0, 2};
      vecs[2]  = '{3'd3, 32'h100, 32'h100,      32'h11223344, 4'hF, 32'h11223344, 32'h0,        2'd0, 2};
      vecs[3]  = '{3'd3, 32'h4,   32'h102,      32'h00AB0000, 4'h4, 32'h12345678, 32'h0,        2'd0, 2};
      vecs[4]  = '{3'd2, 32'h100, 32'h100,      32'h0,        4'h0, 32'h11AB3344, 32'h11AB3344, 2'd0, 2};
      vecs[5]  = '{3'd3, 32'h8,   32'h8,        32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 32'h11AB3344, 2'd0, 2};
      vecs[6]  = '{3'd3, 32'h8,   32'h8,        32'h0,        4'h0, 32'hDEADBEEF, 32'h11AB3344, 2'd0, 2};
      vecs[7]  = '{3'd4, 32'h100, 32'hFFFFFFFF, 32'h0,        4'h0, 32'h11AB3344, 32'h11AB3344, 2'd0, 2};
      vecs[8]  = '{3'd2, 32'h8,   32'h7,        32'h0,        4'h0, 32'hDEADBEEF, 32'h12345678, 2'd0, 2};
      vecs[9]  = '{3'd3, 32'hFFC, 32'hFFC,      32'hA5A55A5A, 4'hF, 32'hA5A55A5A, 32'h12345678, 2'd0, 2};
      vecs[10] = '{3'd2, 32'h4,   32'hFFC,      32'h0,        4'h0, 32'h12345678, 32'hA5A55A5A, 2'd0, 2};
      vecs[11] = '{3'd3, 32'h100, 32'h101,      32'h000000EE, 4'h1, 32'h11AB33EE, 32'hA5A55A5A, 2'd0, 2};
      vecs[12] = '{3'd3, 32'h100, 32'h103,      32'h77000000, 4'h8, 32'h77AB33EE, 32'hA5A55A5A, 2'd0, 2};
      vecs[13] = '{3'd2, 32'hFFC, 32'h100,      32'h0,        4'h0, 32'hA5A55A5A, 32'h77AB33EE, 2'd0, 2};

      do_reset();
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_msr", 32'(mem_start_ready), 32'd0);
      chk("rst_inst", inst_rdata, 32'd63);
      chk("rst_data", data_rdata, 32'd0);
      chk("rst_err", 32'(error), 32'd0);
      wait_start(n);
      chk("init_cycles", 32'(n), 32'd4);
      chk("init_ready", 32'(ready), 32'd1);
      chk("init_inst_nop", inst_rdata, 32'd63);

      for (int i = 0; i < 14; i++) begin
         issue(vecs[i].cmd, vecs[i].pc, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, lat);
         chk($sformatf("v%0d_inst", i), inst_rdata, vecs[i].exp_inst);
         chk($sformatf("v%0d_data", i), data_rdata, vecs[i].exp_data);
         chk($sformatf("v%0d_err", i), 32'(error), 32'(vecs[i].exp_err));
         chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
      end

      // Out-of-range read, then a write that ERR must swallow.
      issue(3'd2, 32'h100, 32'h1000, 32'h0, 4'h0, lat);
      chk("e1_err", 32'(error), 32'd1);
      chk("e1_lat", 32'(lat), 32'd0);
      chk("e1_ready", 32'(ready), 32'd1);
      chk("e1_msr", 32'(mem_start_ready), 32'd1);
      issue(3'd3, 32'h100, 32'h100, 32'h0, 4'hF, lat);
      chk("e1_wr_lat", 32'(lat), 32'd0);
      chk("e1_sticky", 32'(error), 32'd1);
      do_reset();
      chk("e1_rst_err", 32'(error), 32'd0);
      wait_start(n);
      issue(3'd2, 32'h100, 32'h100, 32'h0, 4'h0, lat);
      chk("e1_ram_kept", data_rdata, 32'h77AB33EE);

      do_reset();
      wait_start(n);
      issue(3'd3, 32'h0, 32'h6, 32'h0, 4'hF, lat);
      chk("e2_wr_misalign", 32'(error), 32'd2);
      chk("e2_lat", 32'(lat), 32'd0);

      do_reset();
      wait_start(n);
      issue(3'd1, 32'h2, 32'h0, 32'h0, 4'h0, lat);
      chk("e2_pc_misalign", 32'(error), 32'd2);

      do_reset();
      wait_start(n);
      issue(3'd3, 32'h1000, 32'h6, 32'h0, 4'hF, lat);
      chk("e_priority", 32'(error), 32'd1);

      do_reset();
      wait_start(n);
      issue(3'd6, 32'h0, 32'h0, 32'h0, 4'h0, lat);
      chk("e3_err", 32'(error), 32'd3);
      issue(3'd1, 32'h4, 32'h0, 32'h0, 4'h0, lat);
      chk("e3_ignored_lat", 32'(lat), 32'd0);
      chk("e3_ignored_inst", inst_rdata, 32'd63);
      chk("e3_sticky", 32'(error), 32'd3);

      // Reset one cycle after a write is captured must discard it.
      do_reset();
      wait_start(n);
      issue(3'd3, 32'h14, 32'h14, 32'h55555555, 4'hF, lat);
      chk("mb_pre_inst", inst_rdata, 32'h55555555);
      command    = 3'd3;
      PC         = 32'h14;
      data_addr  = 32'h14;
      data_wdata = 32'h66666666;
      data_wstrb = 4'hF;
      @(negedge clk);
      chk("mb_busy", 32'(ready), 32'd0);
      command = 3'd0;
      rst     = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("mb_rst_inst", inst_rdata, 32'd63);
      chk("mb_rst_data", data_rdata, 32'd0);
      chk("mb_rst_ready", 32'(ready), 32'd0);
      wait_start(n);
      chk("mb_init_cycles", 32'(n), 32'd4);
      issue(3'd2, 32'h14, 32'h14, 32'h0, 4'h0, lat);
      chk("mb_old_data", data_rdata, 32'h55555555);
      chk("mb_old_inst", inst_rdata, 32'h55555555);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/agp32_mem_responder.md
Name: agp32_mem_responder

Overview:
- Memory-side responder for the agp32 processor's command/ready memory interface.
- Accepts one command at a time: instruction fetch, data read, data write or interrupt-fetch.
- Serves each command from an internal word-organised RAM after a programmable latency, then re-asserts ready with fetch and read data valid.
- Also generates the start-up handshake (mem_start_ready) and reports sticky error codes.

Parameters:
- DEPTH, 1024, number of 32-bit words in the internal RAM; byte address range is 0 to 4*DEPTH-1.
- LATENCY, 2, cycles from command capture to ready re-assertion; legal range 1 to 15.
- INIT_CYCLES, 4, cycles after reset before mem_start_ready and ready rise; legal range 1 to 255.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- command  input  3  0 idle, 1 fetch, 2 read+fetch, 3 write+fetch, 4 interrupt (fetch only), 5-7 illegal.
- PC  input  32  instruction fetch byte address.
- data_addr  input  32  data byte address for commands 2 and 3.
- data_wdata  input  32  write data.
- data_wstrb  input  4  byte-lane write enables.
- ready  output  1  1 = idle and outputs valid, command may be issued.
- inst_rdata  output  32  instruction word at PC.
- data_rdata  output  32  word at data_addr (word granular, low 2 bits ignored).
- mem_start_ready  output  1  initialisation complete; stays high until reset.
- error  output  2  0 ok, 1 address out of range, 2 misaligned, 3 illegal command; sticky.

Behaviour:
- Reset values: ready=0, mem_start_ready=0, inst_rdata=32'd63 (NOP), data_rdata=0, error=0, state=INIT. RAM contents are not cleared.
- INIT: counter loads INIT_CYCLES at reset. When it expires, mem_start_ready<=1, ready<=1, go IDLE.
- IDLE: command is sampled only at an edge where ready==1.
  - command==0: no action.
  - command 1-4: capture PC, data_addr, data_wdata, data_wstrb and command. Set ready<=0, load the latency counter with LATENCY, go BUSY.
  - command 5-7: error<=3, go ERR.
- Error checks, evaluated at capture with priority 1 over 2:
  - Code 1: PC >= 4*DEPTH, or data_addr >= 4*DEPTH for commands 2 or 3.
  - Code 2: PC[1:0]!=0, or command 3 with data_wstrb==4'hF and data_addr[1:0]!=0.
  - Error capture sets error and goes to ERR without entering BUSY. RAM is unmodified.
- BUSY: counter decrements each cycle. In the cycle it reaches 0:
  - Command 3: write RAM[data_addr>>2] lanes enabled by data_wstrb.
  - Command 2: data_rdata <= RAM[data_addr>>2].
  - All commands: inst_rdata <= RAM[PC>>2], read after the write, so a write to the PC word returns the new value.
  - ready<=1, go IDLE.
  - Total latency: ready low for exactly LATENCY cycles after the capture edge.
- data_rdata holds its last value for commands 1, 3 and 4.
- data_wstrb==0 on command 3 is a legal no-write; the fetch is still performed.
- Command 4 ignores data_addr and performs a fetch only.
- ERR: ready=1, mem_start_ready=1, error held. All commands are ignored and there are no RAM writes. Only rst exits.
- Commands changing while BUSY are ignored, since only captured values are used.
- Reset mid-BUSY: the pending write is discarded and outputs return to reset values.

Optional Feature:
- Macro: AGP32_MEM_LOAD_PORT_EN.
- Defined: adds ports load_en (in, 1), load_addr (in, 32, word index) and load_data (in, 32).
  - Writes are accepted only in INIT or IDLE. A load_en in BUSY or ERR is dropped.
  - While load_en is high in INIT, the INIT counter is held, so the program is preloaded before start.
  - load_addr >= DEPTH is ignored with no error.
- Undefined: no load ports. RAM is initialised only via simulator/readmem.

Test Plan:
- Start-up: rst high 2 cycles then low, INIT_CYCLES=4 -> mem_start_ready and ready rise exactly 4 cycles after rst falls; inst_rdata=32'd63 until first fetch.
- Fetch: RAM[1]=32'h12345678, command=1 with PC=4 for one cycle while ready=1 -> ready low 2 cycles, then ready=1, inst_rdata=32'h12345678, data_rdata unchanged.
- Byte write then read: command=3, addr=32'h102, wstrb=4'b0100, wdata=32'h00AB0000 over word 32'h11223344 -> then command=2, addr=32'h100 returns data_rdata=32'h11AB3344.
- Write to PC word: command=3, PC=8, addr=8, wstrb=4'hF, wdata=32'hDEADBEEF -> inst_rdata=32'hDEADBEEF at ready.
- Errors:
  - command=2 with data_addr=4*DEPTH -> error=1, ready stays 1, a following write leaves RAM unchanged.
  - After reset, command=3, addr=32'h6, wstrb=4'hF -> error=2.
  - After reset, command=6 -> error=3.
- Reset mid-BUSY: command=3 to word 5, rst asserted on the following cycle -> after INIT, command=2 to word 5 returns the old value.
